// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encoding and default widths for the acquisition sequencer
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ARM  = 2'd2,
        PST  = 2'd3
    } acq_state_t;

    localparam int ACQ_DW = 16;
    localparam int ACQ_CW = 32;
    localparam int ACQ_AW = 14;

endpackage

// File: rtl/acq_ctl.sv
// rtl/acq_ctl.sv - acquisition sequencer gating the ADC stream into the capture buffer
module acq_ctl
    import acq_pkg::*;
#(
    parameter int DW = ACQ_DW,
    parameter int CW = ACQ_CW,
    parameter int AW = ACQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_start,
    input  logic          ctl_stop,
    input  logic          ctl_trg_sw,
    input  logic          trg_hw,
    input  logic [CW-1:0] cfg_pre,
    input  logic [CW-1:0] cfg_pst,
    input  logic [DW-1:0] sti_tdata,
    input  logic          sti_tvalid,
    output logic          sti_tready,
    output logic [DW-1:0] sto_tdata,
    output logic          sto_tvalid,
    input  logic          sto_tready,
    output logic          sto_tlast,
    output logic          buf_rst,
    output logic [1:0]    sts_state,
    output logic [CW-1:0] sts_pre_cnt,
    output logic [CW-1:0] sts_pst_cnt,
    output logic [AW-1:0] sts_trg_ptr,
    output logic          sts_done,
    output logic          sts_abort
);

    acq_state_t    state_q, state_d;
    logic [CW-1:0] pre_cnt_q, pre_cnt_d;
    logic [CW-1:0] pst_cnt_q, pst_cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] trg_ptr_q, trg_ptr_d;
    logic          buf_rst_q, buf_rst_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          trg_hw_q;

    logic          xfer;
    logic          trg;
    logic          tlast;
    logic [CW-1:0] pst_last;
    logic [CW-1:0] pre_cnt_inc;

    always_comb begin
        sto_tdata = sti_tdata;
        if (state_q == IDLE) begin
            sto_tvalid = 1'b0;
            sti_tready = 1'b1;
        end else begin
            sto_tvalid = sti_tvalid;
            sti_tready = sto_tready;
        end
    end

    assign xfer        = sto_tvalid & sto_tready;
    assign trg         = ctl_trg_sw | (trg_hw & ~trg_hw_q);
    assign pst_last    = (cfg_pst == '0) ? '0 : cfg_pst - CW'(1);
    assign pre_cnt_inc = pre_cnt_q + CW'(1);

    // The trigger cycle's own sample is post sample #1, so a one-sample capture
    // must mark it last already in ARM or the buffer would never see tlast.
    assign tlast = ((state_q == PST) || ((state_q == ARM) && trg))
                   && (pst_cnt_q == pst_last);

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pst_cnt_d = pst_cnt_q;
        wptr_d    = wptr_q + AW'(xfer);
        trg_ptr_d = trg_ptr_q;
        buf_rst_d = 1'b0;
        done_d    = done_q;
        abort_d   = abort_q;

        if (ctl_stop) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                abort_d = 1'b1;
            end
        end else if (ctl_start) begin
            buf_rst_d = 1'b1;
            pre_cnt_d = '0;
            pst_cnt_d = '0;
            wptr_d    = '0;
            done_d    = 1'b0;
            abort_d   = 1'b0;
            state_d   = (cfg_pre == '0) ? ARM : PRE;
        end else begin
            case (state_q)
                PRE: begin
                    if (xfer && (pre_cnt_q != cfg_pre)) begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == cfg_pre) state_d = ARM;
                    end
                end
                ARM: begin
                    if (trg) begin
                        trg_ptr_d = wptr_q;
                        state_d   = PST;
                        if (xfer) begin
                            pst_cnt_d = pst_cnt_q + CW'(1);
                            if (tlast) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                PST: begin
                    if (xfer) begin
                        pst_cnt_d = pst_cnt_q + CW'(1);
                        if (tlast) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            pst_cnt_q <= '0;
            wptr_q    <= '0;
            trg_ptr_q <= '0;
            buf_rst_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            trg_hw_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            pst_cnt_q <= pst_cnt_d;
            wptr_q    <= wptr_d;
            trg_ptr_q <= trg_ptr_d;
            buf_rst_q <= buf_rst_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            trg_hw_q  <= trg_hw;
        end
    end

    assign sto_tlast   = tlast;
    assign buf_rst     = buf_rst_q;
    assign sts_state   = state_q;
    assign sts_pre_cnt = pre_cnt_q;
    assign sts_pst_cnt = pst_cnt_q;
    assign sts_trg_ptr = trg_ptr_q;
    assign sts_done    = done_q;
    assign sts_abort   = abort_q;

endmodule

// File: tb/tb_acq_ctl.sv
// tb/tb_acq_ctl.sv - directed self-checking bench for the acquisition sequencer
module tb_acq_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctl_start, ctl_stop, ctl_trg_sw, trg_hw;
    logic [31:0] cfg_pre, cfg_pst;
    logic [15:0] sti_tdata;
    logic        sti_tvalid, sti_tready;
    logic [15:0] sto_tdata;
    logic        sto_tvalid, sto_tready, sto_tlast;
    logic        buf_rst;
    logic [1:0]  sts_state;
    logic [31:0] sts_pre_cnt, sts_pst_cnt;
    logic [13:0] sts_trg_ptr;
    logic        sts_done, sts_abort;

    int checks = 0;
    int errors = 0;
    int xc;
    logic [15:0] exp_data;

    always #5 clk = ~clk;

    acq_ctl dut (
        .clk(clk), .rst(rst),
        .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_trg_sw(ctl_trg_sw), .trg_hw(trg_hw),
        .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
        .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
        .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready), .sto_tlast(sto_tlast),
        .buf_rst(buf_rst), .sts_state(sts_state),
        .sts_pre_cnt(sts_pre_cnt), .sts_pst_cnt(sts_pst_cnt), .sts_trg_ptr(sts_trg_ptr),
        .sts_done(sts_done), .sts_abort(sts_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_acq();
        ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ctl_start = 0; ctl_stop = 0; ctl_trg_sw = 0; trg_hw = 0;
        cfg_pre = 4; cfg_pst = 3; sti_tdata = 16'h1234; sti_tvalid = 1; sto_tready = 1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", sts_state, 0);
        chk("rst_pre", sts_pre_cnt, 0);
        chk("rst_pst", sts_pst_cnt, 0);
        chk("rst_ptr", sts_trg_ptr, 0);
        chk("rst_flags", {buf_rst, sts_done, sts_abort}, 0);
        chk("idle_stream", {sti_tready, sto_tvalid}, 2'b10);

        // pre=4, pst=3, continuous stream, software trigger
        start_acq();
        chk("t1_state_pre", sts_state, 1);
        chk("t1_buf_rst", buf_rst, 1);
        chk("t1_pass_data", sto_tdata, 16'h1234);
        tick();
        chk("t1_buf_rst_clr", buf_rst, 0);
        chk("t1_pre1", sts_pre_cnt, 1);
        tick(); tick(); tick();
        chk("t1_state_arm", sts_state, 2);
        chk("t1_pre4", sts_pre_cnt, 4);
        tick(); tick();
        chk("t1_arm_hold", sts_pre_cnt, 4);
        ctl_trg_sw = 1'b1;
        #1;
        chk("t1_tlast_trg", sto_tlast, 0);
        tick();
        ctl_trg_sw = 1'b0;
        chk("t1_state_pst", sts_state, 3);
        chk("t1_trg_ptr", sts_trg_ptr, 6);
        chk("t1_pst1", sts_pst_cnt, 1);
        chk("t1_tlast_no", sto_tlast, 0);
        tick();
        chk("t1_tlast_yes", {sto_tlast, sto_tvalid}, 2'b11);
        tick();
        chk("t1_idle", sts_state, 0);
        chk("t1_done", sts_done, 1);
        chk("t1_pst3", sts_pst_cnt, 3);
        chk("t1_idle_stream", {sti_tready, sto_tvalid}, 2'b10);

        // pre=0, pst=0 (treated as 1), hardware edge
        cfg_pre = 0; cfg_pst = 0;
        start_acq();
        chk("t2_state_arm", sts_state, 2);
        chk("t2_done_clr", sts_done, 0);
        tick();
        trg_hw = 1'b1;
        #1;
        chk("t2_tlast_trg", sto_tlast, 1);
        tick();
        chk("t2_idle", sts_state, 0);
        chk("t2_done", sts_done, 1);
        chk("t2_pst1", sts_pst_cnt, 1);
        chk("t2_trg_ptr", sts_trg_ptr, 1);
        start_acq();
        tick(); tick();
        chk("t2_no_retrig", sts_state, 2);
        chk("t2_no_tlast", sto_tlast, 0);
        trg_hw = 1'b0;

        // triggers during PRE are ignored
        cfg_pre = 8; cfg_pst = 2;
        start_acq();
        ctl_trg_sw = 1'b1; trg_hw = 1'b1;
        tick();
        ctl_trg_sw = 1'b0; trg_hw = 1'b0;
        chk("t3_still_pre", sts_state, 1);
        chk("t3_pre1", sts_pre_cnt, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_pre7", sts_pre_cnt, 7);
        tick();
        chk("t3_arm", sts_state, 2);
        ctl_trg_sw = 1'b1;
        tick();
        ctl_trg_sw = 1'b0;
        chk("t3_pst", sts_state, 3);
        chk("t3_tlast", sto_tlast, 1);
        tick();
        chk("t3_done", {sts_state, sts_done}, 3'b001);
        chk("t3_pst_final", sts_pst_cnt, 2);

        // 50% backpressure in PST, pst=5
        cfg_pre = 1; cfg_pst = 5;
        start_acq();
        tick();
        chk("t4_arm", sts_state, 2);
        sto_tready = 1'b0; ctl_trg_sw = 1'b1;
        tick();
        ctl_trg_sw = 1'b0;
        chk("t4_pst0", sts_pst_cnt, 0);
        xc = 0; exp_data = 16'h0100;
        for (int i = 0; i < 40; i++) begin
            if (sts_state != 2'd3) break;
            sto_tready = i[0];
            sti_tdata  = exp_data;
            #1;
            chk("t4_tlast", sto_tlast, (xc == 4));
            if (sto_tvalid && sto_tready) begin
                chk("t4_data", sto_tdata, 16'h0100 + 16'(xc));
                xc++;
                exp_data = exp_data + 16'd1;
            end
            tick();
        end
        sto_tready = 1'b1;
        chk("t4_idle", sts_state, 0);
        chk("t4_xfers", xc, 5);
        chk("t4_pst5", sts_pst_cnt, 5);
        chk("t4_done", sts_done, 1);

        // stop in PST after two post samples
        cfg_pre = 0; cfg_pst = 10;
        start_acq();
        ctl_trg_sw = 1'b1;
        tick();
        ctl_trg_sw = 1'b0;
        tick();
        chk("t5_pst2", sts_pst_cnt, 2);
        chk("t5_state", sts_state, 3);
        ctl_stop = 1'b1;
        #1;
        chk("t5_no_tlast", sto_tlast, 0);
        tick();
        ctl_stop = 1'b0;
        chk("t5_idle", sts_state, 0);
        chk("t5_abort", {sts_abort, sts_done}, 2'b10);
        tick();
        chk("t5_drain", {sti_tready, sto_tvalid}, 2'b10);

        // start+stop together, then reset mid-PST
        cfg_pre = 8;
        start_acq();
        ctl_start = 1'b1; ctl_stop = 1'b1;
        tick();
        ctl_start = 1'b0; ctl_stop = 1'b0;
        chk("t6_stop_wins", {sts_state, sts_abort, buf_rst}, 4'b0010);
        cfg_pre = 0;
        start_acq();
        ctl_trg_sw = 1'b1;
        tick();
        ctl_trg_sw = 1'b0;
        chk("t6_pst", sts_state, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_state", sts_state, 0);
        chk("t6_rst_cnt", {sts_pre_cnt, sts_pst_cnt} == 64'd0, 1);
        chk("t6_rst_ptr", sts_trg_ptr, 0);
        chk("t6_rst_flags", {buf_rst, sts_done, sts_abort, sto_tlast, sto_tvalid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
